// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the MTM ALU serial response path.
// Used by the serializer and reusable by the input deserializer.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TYPE,
    S_DATA,
    S_STOP
  } ser_state_e;

  localparam logic TYPE_DATA = 1'b0;
  localparam logic TYPE_CTL  = 1'b1;

  localparam int FRAME_BITS    = 11;
  localparam int RESULT_FRAMES = 5;

  // Bit positions inside the 3-bit error flag vector {ERR_DATA, ERR_CRC, ERR_OP}
  localparam int ERR_DATA_POS = 2;
  localparam int ERR_CRC_POS  = 1;
  localparam int ERR_OP_POS   = 0;

  // x^3 + x + 1 with the implicit x^3 term dropped
  localparam logic [2:0] CRC3_POLY = 3'b011;

  // Field order of the CTL payload; bits [2:0] hold the CRC (or parity in an error frame)
  localparam int CTL_ERR_POS   = 7;
  localparam int CTL_CARRY_POS = 6;
  localparam int CTL_OVF_POS   = 5;
  localparam int CTL_ZERO_POS  = 4;
  localparam int CTL_NEG_POS   = 3;

  typedef struct packed {
    logic        err;
    logic [2:0]  err_flags;
    logic [31:0] c;
    logic        carry;
    logic        overflow;
  } resp_t;

  function automatic logic [7:0] err_payload(input logic [2:0] flags);
    logic [7:0] p;
    p              = '0;
    p[CTL_ERR_POS] = 1'b1;
    p[6]           = flags[ERR_DATA_POS];
    p[5]           = flags[ERR_CRC_POS];
    p[4]           = flags[ERR_OP_POS];
    p[3]           = flags[ERR_DATA_POS];
    p[2]           = flags[ERR_CRC_POS];
    p[1]           = flags[ERR_OP_POS];
    p[0]           = ^p[7:1];
    return p;
  endfunction

endpackage

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC3 (x^3+x+1, init 000) over a 37-bit message, MSB first.
module mtm_alu_crc3
  import mtm_alu_pkg::*;
(
  input  logic [36:0] msg_i,
  output logic [2:0]  crc_o
);

  logic [2:0] crc;
  logic       fb;

  always_comb begin
    crc = 3'b000;
    fb  = 1'b0;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg_i[i];
      crc = {crc[1:0], 1'b0};
      if (fb) crc = crc ^ CRC3_POLY;
    end
    crc_o = crc;
  end

endmodule

// File: rtl/mtm_alu_serializer.sv
// MTM ALU response serializer: result/error word to 11-bit serial frames, line idles high.
// Optional one-entry holding buffer enabled by defining MTM_ALU_SER_BUF_EN.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_err,
  input  logic [2:0]  in_err_flags,
  input  logic [31:0] in_c,
  input  logic        in_carry,
  input  logic        in_overflow,
  output logic        sout,
  output logic        busy
);

  localparam logic [7:0] DIV_RELOAD     = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_FRAME_IDX = 3'(RESULT_FRAMES - 1);
  localparam logic [2:0] DATA_MSB       = 3'(FRAME_BITS - 4);

  ser_state_e  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  frame_idx_q, frame_idx_d;
  resp_t       shadow_q, shadow_d;

  resp_t       in_resp;
  resp_t       start_resp;
  logic        accept;
  logic        start_new;
  logic        bit_end;
  logic        last_frame;

  logic        zero;
  logic        neg;
  logic [2:0]  crc;
  logic [7:0]  ctl_payload;
  logic [7:0]  payload;
  logic        type_bit;

  assign in_resp    = {in_err, in_err_flags, in_c, in_carry, in_overflow};
  assign accept     = in_valid && in_ready;
  assign bit_end    = (div_q == 8'd0);
  assign last_frame = (frame_idx_q == LAST_FRAME_IDX);

`ifdef MTM_ALU_SER_BUF_EN
  resp_t buf_q, buf_d;
  logic  buf_vld_q, buf_vld_d;
  logic  resp_done;

  assign resp_done  = (state_q == S_STOP) && bit_end && last_frame;
  assign in_ready   = !buf_vld_q;
  // A held response wins; with an empty buffer a fresh accept goes straight to the shadow
  assign start_new  = ((state_q == S_IDLE) || resp_done) && (buf_vld_q || accept);
  assign start_resp = buf_vld_q ? buf_q : in_resp;

  always_comb begin
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    if (start_new && buf_vld_q) buf_vld_d = 1'b0;
    if (accept && !(start_new && !buf_vld_q)) begin
      buf_d     = in_resp;
      buf_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
    end
  end
`else
  assign in_ready   = (state_q == S_IDLE);
  assign start_new  = (state_q == S_IDLE) && accept;
  assign start_resp = in_resp;
`endif

  assign zero = (shadow_q.c == 32'd0);
  assign neg  = shadow_q.c[31];

  mtm_alu_crc3 u_crc3 (
    .msg_i ({shadow_q.c, 1'b0, shadow_q.carry, shadow_q.overflow, zero, neg}),
    .crc_o (crc)
  );

  always_comb begin
    ctl_payload                = '0;
    ctl_payload[CTL_ERR_POS]   = 1'b0;
    ctl_payload[CTL_CARRY_POS] = shadow_q.carry;
    ctl_payload[CTL_OVF_POS]   = shadow_q.overflow;
    ctl_payload[CTL_ZERO_POS]  = zero;
    ctl_payload[CTL_NEG_POS]   = neg;
    ctl_payload[2:0]           = crc;

    payload = ctl_payload;
    if (shadow_q.err) begin
      payload = err_payload(shadow_q.err_flags);
    end else begin
      case (frame_idx_q)
        3'd0:    payload = shadow_q.c[31:24];
        3'd1:    payload = shadow_q.c[23:16];
        3'd2:    payload = shadow_q.c[15:8];
        3'd3:    payload = shadow_q.c[7:0];
        default: payload = ctl_payload;
      endcase
    end
  end

  assign type_bit = (shadow_q.err || last_frame) ? TYPE_CTL : TYPE_DATA;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_idx_d   = bit_idx_q;
    frame_idx_d = frame_idx_q;
    shadow_d    = shadow_q;

    if (state_q != S_IDLE) begin
      if (!bit_end) begin
        div_d = div_q - 8'd1;
      end else begin
        div_d = DIV_RELOAD;
        case (state_q)
          S_START: state_d = S_TYPE;
          S_TYPE: begin
            state_d   = S_DATA;
            bit_idx_d = DATA_MSB;
          end
          S_DATA: begin
            if (bit_idx_q == 3'd0) state_d = S_STOP;
            else bit_idx_d = bit_idx_q - 3'd1;
          end
          S_STOP: begin
            if (last_frame) begin
              state_d = S_IDLE;
            end else begin
              frame_idx_d = frame_idx_q + 3'd1;
              state_d     = S_START;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // An error response is a single CTL frame, so it starts on the last frame index
    if (start_new) begin
      state_d     = S_START;
      div_d       = DIV_RELOAD;
      bit_idx_d   = DATA_MSB;
      frame_idx_d = start_resp.err ? LAST_FRAME_IDX : 3'd0;
      shadow_d    = start_resp;
    end
  end

  always_comb begin
    sout = 1'b1;
    case (state_q)
      S_START: sout = 1'b0;
      S_TYPE:  sout = type_bit;
      S_DATA:  sout = payload[bit_idx_q];
      default: sout = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_idx_q   <= '0;
      frame_idx_q <= '0;
      shadow_q    <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      frame_idx_q <= frame_idx_d;
      shadow_q    <= shadow_d;
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Scoreboard bench for mtm_alu_serializer: one instance at 1 clk/bit, one at 4 clk/bit.
// Expectations follow MTM_ALU_SER_BUF_EN when it is defined for the build.
module tb_mtm_alu_serializer;
  import mtm_alu_pkg::*;

`ifdef MTM_ALU_SER_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        rst1 = 1'b1, v1 = 1'b0, err1 = 1'b0, cy1 = 1'b0, ov1 = 1'b0;
  logic [2:0]  fl1 = '0;
  logic [31:0] c1 = '0;
  logic        rdy1, so1, busy1;

  logic        rst4 = 1'b1, v4 = 1'b0, err4 = 1'b0, cy4 = 1'b0, ov4 = 1'b0;
  logic [2:0]  fl4 = '0;
  logic [31:0] c4 = '0;
  logic        rdy4, so4, busy4;

  logic [10:0] exp1[$];
  logic [10:0] exp4[$];

  mtm_alu_serializer #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .in_valid(v1), .in_ready(rdy1), .in_err(err1),
    .in_err_flags(fl1), .in_c(c1), .in_carry(cy1), .in_overflow(ov1),
    .sout(so1), .busy(busy1)
  );

  mtm_alu_serializer #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst4), .in_valid(v4), .in_ready(rdy4), .in_err(err4),
    .in_err_flags(fl4), .in_c(c4), .in_carry(cy4), .in_overflow(ov4),
    .sout(so4), .busy(busy4)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endfunction

  function automatic logic [10:0] mkframe(input logic ctl, input logic [7:0] pl);
    return {1'b0, ctl, pl, 1'b1};
  endfunction

  // Reference CRC by long division of the message augmented with three zeros
  function automatic logic [2:0] crc3_ref(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  // Monitor for the 1 clk/bit instance; a reset inside a frame abandons the response
  logic [10:0] fr1;
  bit          ab1;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst1 && so1 == 1'b0) begin
        fr1 = '0;
        ab1 = 1'b0;
        for (int b = 0; b < FRAME_BITS; b++) begin
          if (b > 0) @(negedge clk);
          if (rst1) begin
            ab1 = 1'b1;
            break;
          end
          fr1 = {fr1[9:0], so1};
        end
        if (ab1) exp1.delete();
        else if (exp1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dut1_frame: got unexpected frame 0x%03h, want none", fr1);
        end else check("dut1_frame", 32'(fr1), 32'(exp1.pop_front()));
      end
    end
  end

  // Monitor for the 4 clk/bit instance; also requires every bit to hold for all 4 cycles
  logic [10:0] fr4;
  logic        bv4, hold4;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst4 && so4 == 1'b0) begin
        fr4   = '0;
        hold4 = 1'b0;
        for (int b = 0; b < FRAME_BITS; b++) begin
          for (int k = 0; k < 4; k++) begin
            if (b > 0 || k > 0) @(negedge clk);
            if (k == 0) bv4 = so4;
            else if (so4 !== bv4) hold4 = 1'b1;
          end
          fr4 = {fr4[9:0], bv4};
        end
        check("dut4_bit_hold", 32'(hold4), 32'd0);
        if (exp4.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL dut4_frame: got unexpected frame 0x%03h, want none", fr4);
        end else check("dut4_frame", 32'(fr4), 32'(exp4.pop_front()));
      end
    end
  end

  task automatic send1(input logic e, input logic [2:0] f, input logic [31:0] c,
                       input logic cy, input logic ov);
    logic r;
    bit   ok;
    err1 = e; fl1 = f; c1 = c; cy1 = cy; ov1 = ov; v1 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      r = rdy1;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    v1 = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dut1_accept: got no handshake in 200 cycles, want one");
    end
  endtask

  task automatic send4(input logic e, input logic [2:0] f, input logic [31:0] c,
                       input logic cy, input logic ov);
    logic r;
    bit   ok;
    err4 = e; fl4 = f; c4 = c; cy4 = cy; ov4 = ov; v4 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r = rdy4;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    v4 = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dut4_accept: got no handshake in 400 cycles, want one");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r;
    bit          acc;
    int          acck, lowcnt;
    logic [2:0]  cr;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sout1", 32'(so1), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_ready1", 32'(rdy1), 32'd1);
    check("rst_sout4", 32'(so4), 32'd1);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_ready4", 32'(rdy4), 32'd1);
    rst1 = 1'b0;
    rst4 = 1'b0;
    @(posedge clk);
    #1;

    // Zero result: Z=1, CRC=110 -> CTL 0x16, 55 bits
    for (int i = 0; i < 4; i++) exp1.push_back(mkframe(TYPE_DATA, 8'h00));
    exp1.push_back(mkframe(TYPE_CTL, 8'h16));
    send1(1'b0, 3'b000, 32'h0000_0000, 1'b0, 1'b0);
    check("t1_start_bit", 32'(so1), 32'd0);
    check("t1_busy_start", 32'(busy1), 32'd1);
    check("t1_ready_busy", 32'(rdy1), BUF ? 32'd1 : 32'd0);
    repeat (54) @(posedge clk);
    #1;
    check("t1_busy_last_stop", 32'(busy1), 32'd1);
    @(posedge clk);
    #1;
    check("t1_busy_done", 32'(busy1), 32'd0);
    check("t1_idle_sout", 32'(so1), 32'd1);
    check("t1_frames_seen", 32'(exp1.size()), 32'd0);

    // Error ERR_DATA only -> CTL 0xC9, 11 bits; in_c and flags ignored
    exp1.push_back(mkframe(TYPE_CTL, 8'hC9));
    send1(1'b1, 3'b100, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("t2_start_bit", 32'(so1), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("t2_busy_last_stop", 32'(busy1), 32'd1);
    @(posedge clk);
    #1;
    check("t2_busy_done", 32'(busy1), 32'd0);
    check("t2_frames_seen", 32'(exp1.size()), 32'd0);

    // Reset inside the third DATA frame aborts the response
    exp1.push_back(mkframe(TYPE_DATA, 8'h11));
    exp1.push_back(mkframe(TYPE_DATA, 8'h22));
    exp1.push_back(mkframe(TYPE_DATA, 8'h33));
    send1(1'b0, 3'b000, 32'h1122_3344, 1'b0, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    check("t3_rst_sout", 32'(so1), 32'd1);
    check("t3_rst_busy", 32'(busy1), 32'd0);
    check("t3_rst_ready", 32'(rdy1), 32'd1);
    @(posedge clk);
    #1;
    check("t3_rst_stays_idle", 32'(so1), 32'd1);
    // Error ERR_CRC|ERR_OP -> CTL 0xB7
    exp1.push_back(mkframe(TYPE_CTL, 8'hB7));
    send1(1'b1, 3'b011, 32'h0, 1'b0, 1'b0);
    check("t3_restart_start", 32'(so1), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("t3_restart_frames", 32'(exp1.size()), 32'd0);

    // Back-to-back: A = 0xFFFFFFFF C=1 V=1 (N=1, CRC=010 -> 0x6A), B = error ERR_OP (0x93)
    for (int i = 0; i < 4; i++) exp1.push_back(mkframe(TYPE_DATA, 8'hFF));
    exp1.push_back(mkframe(TYPE_CTL, 8'h6A));
    send1(1'b0, 3'b000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    err1 = 1'b1; fl1 = 3'b001; c1 = 32'h0; cy1 = 1'b0; ov1 = 1'b0; v1 = 1'b1;
    acc = 1'b0;
    acck = 0;
    lowcnt = 0;
    for (int k = 1; k <= 60; k++) begin
      r = rdy1;
      @(posedge clk);
      #1;
      if (!acc) begin
        if (r) begin
          acc  = 1'b1;
          acck = k;
          v1   = 1'b0;
          exp1.push_back(mkframe(TYPE_CTL, 8'h93));
        end else lowcnt++;
      end
      if (k == 55) begin
        check("t4_gap_sout", 32'(so1), BUF ? 32'd0 : 32'd1);
        check("t4_gap_busy", 32'(busy1), BUF ? 32'd1 : 32'd0);
      end
    end
    v1 = 1'b0;
    check("t4_second_accepted", 32'(acc), 32'd1);
    check("t4_accept_cycle", 32'(acck), BUF ? 32'd1 : 32'd56);
    check("t4_ready_low_cycles", 32'(lowcnt), BUF ? 32'd0 : 32'd55);
    repeat (15) @(posedge clk);
    #1;
    check("t4_frames_seen", 32'(exp1.size()), 32'd0);

    // 4 clk/bit: 0x80000001 C=1 -> N=1 Z=0; CRC from reference model (hand value 010 -> 0x4A)
    cr = crc3_ref({32'h8000_0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    exp4.push_back(mkframe(TYPE_DATA, 8'h80));
    exp4.push_back(mkframe(TYPE_DATA, 8'h00));
    exp4.push_back(mkframe(TYPE_DATA, 8'h00));
    exp4.push_back(mkframe(TYPE_DATA, 8'h01));
    exp4.push_back(mkframe(TYPE_CTL, {5'b01001, cr}));
    send4(1'b0, 3'b000, 32'h8000_0001, 1'b1, 1'b0);
    check("t5_start_bit", 32'(so4), 32'd0);
    repeat (219) @(posedge clk);
    #1;
    check("t5_busy_last_cycle", 32'(busy4), 32'd1);
    @(posedge clk);
    #1;
    check("t5_busy_done", 32'(busy4), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_frames_seen", 32'(exp4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
